// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding, data width and
// watchdog counter width.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int WDOG_W      = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one write and one read port; occupancy count is the
// sole source of full/empty so pointers may wrap freely.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_rdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers upstream bytes and hands them to uart_tx one at a time, waiting for
// tx_done (or a watchdog abort) before issuing the next tx_start.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [ADDR_W:0]        count,
  output logic                   timeout
);

  localparam logic [WDOG_W-1:0] TO_LAST =
    (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic [WDOG_W-1:0]      r_timer;
  logic                   r_timeout;
  logic                   w_full;
  logic                   w_empty;
  logic [UART_DATA_W-1:0] w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_abort;
  logic                   w_wdog_hit;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, never on in_valid.
  assign in_ready   = !reset && !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_wdog_hit = (TIMEOUT > 0) && (r_timer == TO_LAST);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          w_state_next = ST_IDLE;
        end else if (w_wdog_hit) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Timer saturates so a disabled watchdog never wraps back into a match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_timer    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) begin
        r_tx_data <= w_head;
        r_timer   <= '0;
      end else if (r_state == ST_WAIT && r_timer != '1) begin
        r_timer <= r_timer + WDOG_W'(1);
      end
      if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign timeout  = r_timeout;
  assign busy     = (count != '0) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a responder models uart_tx, a monitor
// checks every tx_start against the expected byte queue.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              resp_done;
  logic              spur_done;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              timeout;

  logic              wd_in_valid;
  logic [7:0]        wd_in_data;
  logic              wd_in_ready;
  logic              wd_tx_start;
  logic [7:0]        wd_tx_data;
  logic              wd_tx_done;
  logic              wd_busy;
  logic [ADDR_W:0]   wd_count;
  logic              wd_timeout;

  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic [7:0]        exp_q[$];
  int                resp_delay = 3;
  bit                resp_en = 1'b1;
  bit                chk_gap = 1'b0;
  int                last_done_cyc = -1;
  int                last_start_cyc = -1;
  int                push_cyc = -1;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(200000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(resp_done | spur_done), .busy(busy), .count(count), .timeout(timeout)
  );

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(50)) dut_wd (
    .clk(clk), .reset(reset), .in_valid(wd_in_valid), .in_data(wd_in_data),
    .in_ready(wd_in_ready), .tx_start(wd_tx_start), .tx_data(wd_tx_data),
    .tx_done(wd_tx_done), .busy(wd_busy), .count(wd_count), .timeout(wd_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge; the byte transfers at the next posedge.
  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_wait", n < 500, 1);
    in_valid = 1'b1;
    in_data  = b;
    exp_q.push_back(b);
    push_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, n < budget, 1);
  endtask

  // ---------------- uart_tx responder ----------------
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && resp_en) begin
        repeat (resp_delay) @(negedge clk);
        if (!reset) begin
          resp_done     = 1'b1;
          last_done_cyc = cyc;
        end
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        if (chk_gap && last_done_cyc >= 0) check("start_gap", cyc - last_done_cyc, 2);
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got tx_start with tx_data=%0h, expected no tx_start", tx_data);
        end else begin
          check("tx_data", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int s;
    int s2;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    spur_done   = 1'b0;
    wd_in_valid = 1'b0;
    wd_in_data  = 8'h00;
    wd_tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Single byte, tx_done 100 cycles after tx_start.
    resp_delay = 100;
    push(8'hA5);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_start_seen", n < 50, 1);
    check("first_latency", last_start_cyc - push_cyc, 2);
    n = 0;
    while (last_done_cyc < last_start_cyc && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("single_done_seen", n < 200, 1);
    while (cyc < last_done_cyc + 1) @(negedge clk);
    check("single_busy_after_done", busy, 0);
    check("single_count", count, 0);

    // Burst fills the FIFO while the first byte is in flight.
    resp_delay    = 40;
    last_done_cyc = -1;
    chk_gap       = 1'b1;
    for (int i = 0; i <= 16; i++) push(8'(i));
    check("burst_full_count", count, 16);
    check("burst_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (5) @(negedge clk);
    check("burst_held_count", count, 16);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("burst_ready_after_pop", n < 200, 1);
    exp_q.push_back(8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    check("burst_refill_count", count, 16);
    wait_drain("burst", 2000);
    chk_gap = 1'b0;
    check("burst_end_count", count, 0);

    // Wrap-around of pointers.
    resp_delay = 3;
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
    wait_drain("wrap_a", 400);
    check("wrap_a_count", count, 0);
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
    wait_drain("wrap_b", 400);
    check("wrap_b_count", count, 0);

    // Spurious tx_done in IDLE.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    check("spur_tx_start", tx_start, 0);
    check("spur_count", count, 0);
    check("spur_busy", busy, 0);

    // Watchdog on the TIMEOUT=50 instance; tx_done never arrives.
    wd_in_valid = 1'b1;
    wd_in_data  = 8'hB1;
    @(negedge clk);
    wd_in_data  = 8'hB2;
    @(negedge clk);
    wd_in_valid = 1'b0;
    n = 0;
    while (!wd_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wd_first_start_seen", n < 20, 1);
    s = cyc;
    check("wd_first_data", wd_tx_data, 8'hB1);
    repeat (49) @(negedge clk);
    check("wd_timeout_before", wd_timeout, 0);
    check("wd_busy_before", wd_busy, 1);
    @(negedge clk);
    check("wd_timeout_set", wd_timeout, 1);
    n = 0;
    while (!wd_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    s2 = cyc;
    check("wd_second_gap", s2 - s, 51);
    check("wd_second_data", wd_tx_data, 8'hB2);
    repeat (60) @(negedge clk);
    check("wd_timeout_sticky", wd_timeout, 1);
    check("wd_busy_end", wd_busy, 0);
    check("wd_count_end", wd_count, 0);

    // Asynchronous reset while a byte is in flight with 3 queued.
    resp_delay = 100;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    repeat (3) @(negedge clk);
    check("mid_pre_count", count, 3);
    check("mid_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_wd_timeout", wd_timeout, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_post_count", count, 0);
    check("mid_post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
